fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the pipelined TSC core. Owns the PC, issues instruction-memory reads and predicts
//  the next PC using a tagged BTB plus a 2-bit bimodal table. Handles stall/flush/halt and
//  drives the IF/ID pipeline register consumed by decode. Predictor state is trained by
//  branches resolved in EX.
// PARAMETERS
//  WORD_SIZE    16      datapath/address width
//  IDX_BITS     8       predictor index width = PC[IDX_BITS-1:0]; 2**IDX_BITS entries
//  RESET_PC     16'h0   PC loaded on reset
// PORTS
//  clk               in   1   clock, rising edge
//  reset_n           in   1   asynchronous, active-low reset
//  i_readM           out  1   instruction read request, held until i_ready
//  i_address         out  16  fetch address (= PC)
//  i_data            in   16  instruction word, valid when i_ready=1
//  i_ready           in   1   one-cycle pulse: read complete
//  Stall             in   1   decode cannot accept; hold IF/ID
//  Flush             in   1   EX redirect (mispredict/jump)
//  redirect_pc       in   16  correct PC, valid with Flush
//  Halt              in   1   HLT decoded; stop fetching
//  upd_valid         in   1   resolved conditional branch in EX
//  upd_pc            in   16  PC of that branch
//  upd_taken         in   1   actual direction
//  upd_target        in   16  actual taken target
//  ifid_valid        out  1   IF/ID holds a real instruction
//  ifid_inst         out  16  fetched instruction
//  ifid_pc           out  16  PC of ifid_inst
//  ifid_pred_taken   out  1   prediction used for ifid_inst
//  ifid_pred_target  out  16  predicted next PC for ifid_inst
// BEHAVIOUR
//  Reset (async, immediate): PC=RESET_PC; state FETCH; i_readM=0 while reset_n=0; every
//   ifid_* output = 0; all BTB valid bits = 0; all BHT counters = 2'b01 (weakly not-taken).
//  FSM: FETCH -> (i_ready & Stall & !Flush) HOLD; HOLD -> (!Stall) FETCH; any -> (Halt & !Flush) HALTED.
//  FETCH: i_readM=1, i_address=PC. On i_ready & !Stall & !Flush: ifid_* <= {1,i_data,PC,pred},
//   PC <= next. On a cycle with no i_ready and !Stall: ifid_valid <= 0 (bubble).
//  Prediction (combinational on PC): idx=PC[IDX_BITS-1:0], hit = btb_v[idx] & btb_tag[idx]==PC[15:IDX_BITS];
//   taken = hit & bht[idx][1]; next = taken ? btb_tgt[idx] : PC+1 (mod 2**16, 16'hFFFF -> 16'h0000).
//  HOLD: captured word/pred kept in a skid buffer, i_readM=0, ifid_* unchanged. First cycle with
//   !Stall: skid -> IF/ID, PC <= next, return to FETCH. No instruction lost or duplicated.
//  Stall: all ifid_* hold their value; PC holds.
//  Flush (priority over Stall, i_ready, Halt): ifid_valid <= 0, skid discarded, PC <= redirect_pc,
//   state FETCH; data returning in the same cycle is dropped. i_address=redirect_pc next cycle.
//  HALTED: i_readM=0, ifid_valid=0, PC frozen; exit only by reset.
//  Training (every clk with upd_valid, independent of Stall/Flush/Halt): bht[upd idx] +1 if taken
//   (saturate 2'b11), -1 if not (saturate 2'b00). If taken: btb_v=1, tag, tgt=upd_target written.
//   Same-cycle lookup of the same index sees the pre-update value.
//  Latency: min 1 cycle from request to IF/ID when i_ready is returned in the request cycle.
// TESTING
//  1 reset, i_ready=1 every cycle -> i_address 0,1,2,3; ifid_pc 0,1,2 in successive cycles; pred_taken=0.
//  2 upd_valid taken pc=16'h0005 tgt=16'h0020 twice (01->10->11); fetch 0x0005 -> next i_address 0x0020,
//    ifid_pred_taken=1; one not-taken update -> still predicts taken (10).
//  3 Stall=1 in the cycle i_ready returns inst 16'hA123 at PC 4, held 3 cycles -> i_readM=0, ifid unchanged;
//    on release ifid_inst=16'hA123, ifid_pc=4 exactly once, then fetch PC 5.
//  4 Flush with redirect_pc=16'h0100 coinciding with i_ready and Stall -> next cycle ifid_valid=0,
//    i_address=16'h0100, dropped word never appears.
//  5 reset_n low mid-request (between clk edges) -> i_readM and all ifid_* 0 before next edge;
//    after release, fetch resumes at RESET_PC with BHT=01.
//  6 PC=16'hFFFF fetched not-taken -> next i_address 16'h0000; Halt=1 -> i_readM stays 0 for 10 cycles.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response and IF/ID register bus of the fetch stage.
// master = fetch stage, slave = memory/decode side.
interface fetch_stage_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_readM;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_data;
  logic                 i_ready;
  logic                 ifid_valid;
  logic [WORD_SIZE-1:0] ifid_inst;
  logic [WORD_SIZE-1:0] ifid_pc;
  logic                 ifid_pred_taken;
  logic [WORD_SIZE-1:0] ifid_pred_target;

  modport master (
    output i_readM, i_address,
    input  i_data, i_ready,
    output ifid_valid, ifid_inst, ifid_pc, ifid_pred_taken, ifid_pred_target
  );

  modport slave (
    input  i_readM, i_address,
    output i_data, i_ready,
    input  ifid_valid, ifid_inst, ifid_pc, ifid_pred_taken, ifid_pred_target
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, requests imem, predicts next PC (tagged BTB + 2-bit bimodal), drives IF/ID.
// One cycle from i_ready to IF/ID; under Stall a returned word parks in a skid buffer and i_readM drops.
module fetch_stage #(
  parameter int                   WORD_SIZE = 16,
  parameter int                   IDX_BITS  = 8,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fetch_stage_if.master        bus,
  input  logic                 Stall,
  input  logic                 Flush,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 Halt,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic                 upd_taken,
  input  logic [WORD_SIZE-1:0] upd_target
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = WORD_SIZE - IDX_BITS;

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] pc, pc_nxt;

  logic [1:0]           bht     [ENTRIES];
  logic [ENTRIES-1:0]   btb_v;
  logic [TAG_W-1:0]     btb_tag [ENTRIES];
  logic [WORD_SIZE-1:0] btb_tgt [ENTRIES];

  logic [IDX_BITS-1:0]  idx, upd_idx;
  logic                 hit, pred_taken;
  logic [WORD_SIZE-1:0] pred_next;

  logic                 take_fetch, take_skid, load_skid, kill_ifid;

  logic                 ifid_valid, ifid_pred_taken;
  logic [WORD_SIZE-1:0] ifid_inst, ifid_pc, ifid_pred_target;
  logic [WORD_SIZE-1:0] skid_inst, skid_tgt;
  logic                 skid_taken;

  assign idx        = pc[IDX_BITS-1:0];
  assign upd_idx    = upd_pc[IDX_BITS-1:0];
  assign hit        = btb_v[idx] && (btb_tag[idx] == pc[WORD_SIZE-1:IDX_BITS]);
  assign pred_taken = hit && bht[idx][1];
  assign pred_next  = pred_taken ? btb_tgt[idx] : pc + WORD_SIZE'(1);

  // Gated by reset_n so the request drops immediately when reset asserts mid-cycle.
  assign bus.i_readM          = reset_n && (state == FETCH);
  assign bus.i_address        = pc;
  assign bus.ifid_valid       = ifid_valid;
  assign bus.ifid_inst        = ifid_inst;
  assign bus.ifid_pc          = ifid_pc;
  assign bus.ifid_pred_taken  = ifid_pred_taken;
  assign bus.ifid_pred_target = ifid_pred_target;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    take_fetch = 1'b0;
    take_skid  = 1'b0;
    load_skid  = 1'b0;
    kill_ifid  = 1'b0;
    case (state)
      FETCH: begin
        if (Flush) begin
          pc_nxt    = redirect_pc;
          kill_ifid = 1'b1;
        end else if (Halt) begin
          state_nxt = HALTED;
          kill_ifid = !Stall;
        end else if (bus.i_ready) begin
          if (Stall) begin
            state_nxt = HOLD;
            load_skid = 1'b1;
          end else begin
            take_fetch = 1'b1;
            pc_nxt     = pred_next;
          end
        end else begin
          kill_ifid = !Stall;
        end
      end
      HOLD: begin
        if (Flush) begin
          state_nxt = FETCH;
          pc_nxt    = redirect_pc;
          kill_ifid = 1'b1;
        end else if (Halt) begin
          state_nxt = HALTED;
          kill_ifid = !Stall;
        end else if (!Stall) begin
          state_nxt = FETCH;
          take_skid = 1'b1;
          pc_nxt    = skid_tgt;
        end
      end
      HALTED: begin
        kill_ifid = 1'b1;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifid_valid       <= 1'b0;
      ifid_inst        <= '0;
      ifid_pc          <= '0;
      ifid_pred_taken  <= 1'b0;
      ifid_pred_target <= '0;
      skid_inst        <= '0;
      skid_taken       <= 1'b0;
      skid_tgt         <= '0;
    end else begin
      if (take_fetch) begin
        ifid_valid       <= 1'b1;
        ifid_inst        <= bus.i_data;
        ifid_pc          <= pc;
        ifid_pred_taken  <= pred_taken;
        ifid_pred_target <= pred_next;
      end else if (take_skid) begin
        // PC is frozen while parked, so it still names the skid word.
        ifid_valid       <= 1'b1;
        ifid_inst        <= skid_inst;
        ifid_pc          <= pc;
        ifid_pred_taken  <= skid_taken;
        ifid_pred_target <= skid_tgt;
      end else if (kill_ifid) begin
        ifid_valid       <= 1'b0;
      end
      if (load_skid) begin
        skid_inst  <= bus.i_data;
        skid_taken <= pred_taken;
        skid_tgt   <= pred_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btb_v <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        btb_v[upd_idx] <= 1'b1;
        if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
      end else if (bht[upd_idx] != 2'b00) begin
        bht[upd_idx] <= bht[upd_idx] - 2'd1;
      end
    end
  end

  // Tag/target are only meaningful behind btb_v, so they carry no reset.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      btb_tag[upd_idx] <= upd_pc[WORD_SIZE-1:IDX_BITS];
      btb_tgt[upd_idx] <= upd_target;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Scenario-driven bench for fetch_stage: expected IF/ID entries are queued when a fetch is
// driven and popped when the stage presents them.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        Stall, Flush, Halt;
  logic [15:0] redirect_pc;
  logic        upd_valid, upd_taken;
  logic [15:0] upd_pc, upd_target;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
    logic        taken;
    logic [15:0] tgt;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .Stall       (Stall),
    .Flush       (Flush),
    .redirect_pc (redirect_pc),
    .Halt        (Halt),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] imem(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic exp_t mk(input logic [15:0] inst, input logic [15:0] pc,
                              input logic taken, input logic [15:0] tgt);
    exp_t r;
    r.inst  = inst;
    r.pc    = pc;
    r.taken = taken;
    r.tgt   = tgt;
    return r;
  endfunction

  // Drive one cycle of inputs just after a falling edge; return at the next falling edge.
  task automatic step(input logic rdy, input logic [15:0] dat, input logic stall,
                      input logic flush, input logic halt, input logic [15:0] rpc);
    bus.i_ready = rdy;
    bus.i_data  = dat;
    Stall       = stall;
    Flush       = flush;
    Halt        = halt;
    redirect_pc = rpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.i_readM !== 1'b0 || bus.ifid_valid !== 1'b0 || bus.ifid_inst !== 16'h0 ||
        bus.ifid_pc !== 16'h0 || bus.ifid_pred_taken !== 1'b0 || bus.ifid_pred_target !== 16'h0 ||
        bus.i_address !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got readM=%b v=%b inst=%h pc=%h t=%b tgt=%h addr=%h, want all zero",
               bus.i_readM, bus.ifid_valid, bus.ifid_inst, bus.ifid_pc, bus.ifid_pred_taken,
               bus.ifid_pred_target, bus.i_address);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.i_readM !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_readM: got %b want 1", bus.i_readM);
    end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.i_address !== 16'(k)) begin
        errors++;
        $display("FAIL seq_addr: got %h want %h", bus.i_address, 16'(k));
      end
      sb.push_back(mk(imem(16'(k)), 16'(k), 1'b0, 16'(k + 1)));
      step(1'b1, imem(16'(k)), 1'b0, 1'b0, 1'b0, 16'h0);
      e = sb.pop_front();
      checks++;
      if (bus.ifid_valid !== 1'b1 || bus.ifid_inst !== e.inst || bus.ifid_pc !== e.pc ||
          bus.ifid_pred_taken !== e.taken || bus.ifid_pred_target !== e.tgt) begin
        errors++;
        $display("FAIL seq_ifid: got v=%b inst=%h pc=%h t=%b tgt=%h want v=1 inst=%h pc=%h t=%b tgt=%h",
                 bus.ifid_valid, bus.ifid_inst, bus.ifid_pc, bus.ifid_pred_taken, bus.ifid_pred_target,
                 e.inst, e.pc, e.taken, e.tgt);
      end
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    checks++;
    if (bus.ifid_valid !== 1'b0 || bus.i_address !== 16'h0004) begin
      errors++;
      $display("FAIL seq_bubble: got v=%b addr=%h want v=0 addr=0004", bus.ifid_valid, bus.i_address);
    end
  endtask

  task automatic test_predict();
    upd_valid = 1'b1; upd_pc = 16'h0005; upd_taken = 1'b1; upd_target = 16'h0020;
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    upd_valid = 1'b0;
    for (int k = 4; k < 6; k++) begin
      checks++;
      if (bus.i_address !== 16'(k)) begin
        errors++;
        $display("FAIL pred_addr: got %h want %h", bus.i_address, 16'(k));
      end
      sb.push_back(mk(imem(16'(k)), 16'(k), (k == 5), (k == 5) ? 16'h0020 : 16'(k + 1)));
      step(1'b1, imem(16'(k)), 1'b0, 1'b0, 1'b0, 16'h0);
      e = sb.pop_front();
      checks++;
      if (bus.ifid_valid !== 1'b1 || bus.ifid_inst !== e.inst || bus.ifid_pc !== e.pc ||
          bus.ifid_pred_taken !== e.taken || bus.ifid_pred_target !== e.tgt) begin
        errors++;
        $display("FAIL pred_ifid: got v=%b inst=%h pc=%h t=%b tgt=%h want v=1 inst=%h pc=%h t=%b tgt=%h",
                 bus.ifid_valid, bus.ifid_inst, bus.ifid_pc, bus.ifid_pred_taken, bus.ifid_pred_target,
                 e.inst, e.pc, e.taken, e.tgt);
      end
    end
    checks++;
    if (bus.i_address !== 16'h0020) begin
      errors++;
      $display("FAIL pred_target_addr: got %h want 0020", bus.i_address);
    end
    // One not-taken update takes the counter 11 -> 10: still predicted taken.
    upd_valid = 1'b1; upd_taken = 1'b0;
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    upd_valid = 1'b0;
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0005);
    checks++;
    if (bus.ifid_valid !== 1'b0 || bus.i_address !== 16'h0005) begin
      errors++;
      $display("FAIL pred_redirect: got v=%b addr=%h want v=0 addr=0005", bus.ifid_valid, bus.i_address);
    end
    sb.push_back(mk(imem(16'h0005), 16'h0005, 1'b1, 16'h0020));
    step(1'b1, imem(16'h0005), 1'b0, 1'b0, 1'b0, 16'h0);
    e = sb.pop_front();
    checks++;
    if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== e.pc || bus.ifid_pred_taken !== e.taken ||
        bus.ifid_pred_target !== e.tgt || bus.i_address !== 16'h0020) begin
      errors++;
      $display("FAIL pred_weak_taken: got v=%b pc=%h t=%b tgt=%h addr=%h want v=1 pc=%h t=%b tgt=%h addr=0020",
               bus.ifid_valid, bus.ifid_pc, bus.ifid_pred_taken, bus.ifid_pred_target, bus.i_address,
               e.pc, e.taken, e.tgt);
    end
  endtask

  task automatic test_stall();
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0003);
    sb.push_back(mk(imem(16'h0003), 16'h0003, 1'b0, 16'h0004));
    step(1'b1, imem(16'h0003), 1'b0, 1'b0, 1'b0, 16'h0);
    e = sb.pop_front();
    checks++;
    if (bus.ifid_valid !== 1'b1 || bus.ifid_inst !== e.inst || bus.ifid_pc !== e.pc ||
        bus.i_address !== 16'h0004 || bus.i_readM !== 1'b1) begin
      errors++;
      $display("FAIL stall_pre: got v=%b inst=%h pc=%h addr=%h readM=%b want v=1 inst=%h pc=%h addr=0004 readM=1",
               bus.ifid_valid, bus.ifid_inst, bus.ifid_pc, bus.i_address, bus.i_readM, e.inst, e.pc);
    end
    sb.push_back(mk(16'hA123, 16'h0004, 1'b0, 16'h0005));
    step(1'b1, 16'hA123, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.i_readM !== 1'b0 || bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 16'h0003 ||
          bus.ifid_inst !== imem(16'h0003)) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got readM=%b v=%b pc=%h inst=%h want readM=0 v=1 pc=0003 inst=%h",
                 c, bus.i_readM, bus.ifid_valid, bus.ifid_pc, bus.ifid_inst, imem(16'h0003));
      end
      if (c < 2) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    e = sb.pop_front();
    checks++;
    if (bus.ifid_valid !== 1'b1 || bus.ifid_inst !== e.inst || bus.ifid_pc !== e.pc ||
        bus.ifid_pred_taken !== e.taken || bus.ifid_pred_target !== e.tgt ||
        bus.i_address !== 16'h0005 || bus.i_readM !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got v=%b inst=%h pc=%h t=%b tgt=%h addr=%h readM=%b want v=1 inst=%h pc=%h t=%b tgt=%h addr=0005 readM=1",
               bus.ifid_valid, bus.ifid_inst, bus.ifid_pc, bus.ifid_pred_taken, bus.ifid_pred_target,
               bus.i_address, bus.i_readM, e.inst, e.pc, e.taken, e.tgt);
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    checks++;
    if (bus.ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_dup: got v=%b pc=%h want v=0", bus.ifid_valid, bus.ifid_pc);
    end
  endtask

  task automatic test_flush();
    step(1'b1, imem(16'h0005), 1'b1, 1'b1, 1'b0, 16'h0100);
    checks++;
    if (bus.ifid_valid !== 1'b0 || bus.i_address !== 16'h0100 || bus.i_readM !== 1'b1) begin
      errors++;
      $display("FAIL flush_redirect: got v=%b addr=%h readM=%b want v=0 addr=0100 readM=1",
               bus.ifid_valid, bus.i_address, bus.i_readM);
    end
    sb.push_back(mk(imem(16'h0100), 16'h0100, 1'b0, 16'h0101));
    step(1'b1, imem(16'h0100), 1'b0, 1'b0, 1'b0, 16'h0);
    e = sb.pop_front();
    checks++;
    if (bus.ifid_valid !== 1'b1 || bus.ifid_inst !== e.inst || bus.ifid_pc !== e.pc ||
        bus.ifid_pred_target !== e.tgt) begin
      errors++;
      $display("FAIL flush_next: got v=%b inst=%h pc=%h tgt=%h want v=1 inst=%h pc=%h tgt=%h",
               bus.ifid_valid, bus.ifid_inst, bus.ifid_pc, bus.ifid_pred_target, e.inst, e.pc, e.tgt);
    end
  endtask

  task automatic test_async_reset();
    bus.i_ready = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.i_readM !== 1'b0 || bus.ifid_valid !== 1'b0 || bus.ifid_inst !== 16'h0 ||
        bus.ifid_pc !== 16'h0 || bus.ifid_pred_taken !== 1'b0 || bus.ifid_pred_target !== 16'h0 ||
        bus.i_address !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: got readM=%b v=%b inst=%h pc=%h t=%b tgt=%h addr=%h want all zero",
               bus.i_readM, bus.ifid_valid, bus.ifid_inst, bus.ifid_pc, bus.ifid_pred_taken,
               bus.ifid_pred_target, bus.i_address);
    end
    @(negedge clk);
    reset_n = 1'b1;
    // One taken update must flip a weakly-not-taken counter; entry 5 must be forgotten.
    upd_valid = 1'b1; upd_pc = 16'h0007; upd_taken = 1'b1; upd_target = 16'h0040;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.i_address !== 16'(k)) begin
        errors++;
        $display("FAIL post_reset_addr: got %h want %h", bus.i_address, 16'(k));
      end
      sb.push_back(mk(imem(16'(k)), 16'(k), (k == 7), (k == 7) ? 16'h0040 : 16'(k + 1)));
      step(1'b1, imem(16'(k)), 1'b0, 1'b0, 1'b0, 16'h0);
      upd_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== e.pc || bus.ifid_pred_taken !== e.taken ||
          bus.ifid_pred_target !== e.tgt) begin
        errors++;
        $display("FAIL post_reset_ifid: got v=%b pc=%h t=%b tgt=%h want v=1 pc=%h t=%b tgt=%h",
                 bus.ifid_valid, bus.ifid_pc, bus.ifid_pred_taken, bus.ifid_pred_target, e.pc, e.taken, e.tgt);
      end
    end
    checks++;
    if (bus.i_address !== 16'h0040) begin
      errors++;
      $display("FAIL post_reset_target: got %h want 0040", bus.i_address);
    end
  endtask

  task automatic test_wrap_halt();
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
    sb.push_back(mk(imem(16'hFFFF), 16'hFFFF, 1'b0, 16'h0000));
    step(1'b1, imem(16'hFFFF), 1'b0, 1'b0, 1'b0, 16'h0);
    e = sb.pop_front();
    checks++;
    if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== e.pc || bus.ifid_pred_target !== e.tgt ||
        bus.i_address !== 16'h0000) begin
      errors++;
      $display("FAIL wrap: got v=%b pc=%h tgt=%h addr=%h want v=1 pc=ffff tgt=0000 addr=0000",
               bus.ifid_valid, bus.ifid_pc, bus.ifid_pred_target, bus.i_address);
    end
    step(1'b1, imem(16'h0000), 1'b0, 1'b0, 1'b1, 16'h0);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.i_readM !== 1'b0 || bus.ifid_valid !== 1'b0 || bus.i_address !== 16'h0000) begin
        errors++;
        $display("FAIL halted: cycle %0d got readM=%b v=%b addr=%h want readM=0 v=0 addr=0000",
                 c, bus.i_readM, bus.ifid_valid, bus.i_address);
      end
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    Stall       = 1'b0;
    Flush       = 1'b0;
    Halt        = 1'b0;
    redirect_pc = 16'h0;
    upd_valid   = 1'b0;
    upd_taken   = 1'b0;
    upd_pc      = 16'h0;
    upd_target  = 16'h0;
    bus.i_ready = 1'b0;
    bus.i_data  = 16'h0;
    test_reset();
    test_sequential();
    test_predict();
    test_stall();
    test_flush();
    test_async_reset();
    test_wrap_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
